// File: rtl/jtkunio_rom_arb.sv
// Arbiter that shares one 32-bit graphics ROM port among the scroll, char and object fetchers.
// Each requester keeps its private cs/addr/ok/data protocol; a stale rom_ok is never forwarded.
//   state | meaning
//   IDLE  | choose a winner among asserted cs, latch grant and address
//   ISSUE | rom_cs high, rom_ok ignored (may be left over from the previous access)
//   WAIT  | rom_cs high, capture rom_data on rom_ok
//   DONE  | one-cycle ok pulse to the granted requester, rom_cs low
module jtkunio_rom_arb #(
    parameter int AW     = 18,
    parameter int STARVE = 15
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          scr_cs,
    input  logic [AW-1:0] scr_addr,
    output logic          scr_ok,

    input  logic          chr_cs,
    input  logic [AW-1:0] chr_addr,
    output logic          chr_ok,

    input  logic          obj_cs,
    input  logic [AW-1:0] obj_addr,
    output logic          obj_ok,

    output logic [31:0]   req_data,

    output logic          rom_cs,
    output logic [AW-1:0] rom_addr,
    input  logic [31:0]   rom_data,
    input  logic          rom_ok
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [1:0] G_NONE = 2'd0;
    localparam logic [1:0] G_SCR  = 2'd1;
    localparam logic [1:0] G_CHR  = 2'd2;
    localparam logic [1:0] G_OBJ  = 2'd3;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE);

    logic [1:0]    state;
    logic [1:0]    grant;
    logic [3:0]    starve_cnt;

    logic [1:0]    winner;
    logic [AW-1:0] win_addr;
    logic          gnt_cs;
    logic [AW-1:0] gnt_addr;
    logic          obj_promote;
    logic          abort;
    logic          readdr;

    assign obj_promote = (starve_cnt == STARVE_MAX);

    // A starved object fetcher jumps ahead of the fixed scr > chr > obj order.
    always_comb begin
        winner   = G_NONE;
        win_addr = '0;
        if (obj_cs && obj_promote) begin
            winner   = G_OBJ;
            win_addr = obj_addr;
        end else if (scr_cs) begin
            winner   = G_SCR;
            win_addr = scr_addr;
        end else if (chr_cs) begin
            winner   = G_CHR;
            win_addr = chr_addr;
        end else if (obj_cs) begin
            winner   = G_OBJ;
            win_addr = obj_addr;
        end
    end

    always_comb begin
        gnt_cs   = 1'b0;
        gnt_addr = rom_addr;
        case (grant)
            G_SCR: begin
                gnt_cs   = scr_cs;
                gnt_addr = scr_addr;
            end
            G_CHR: begin
                gnt_cs   = chr_cs;
                gnt_addr = chr_addr;
            end
            G_OBJ: begin
                gnt_cs   = obj_cs;
                gnt_addr = obj_addr;
            end
            default: begin
                gnt_cs   = 1'b0;
                gnt_addr = rom_addr;
            end
        endcase
    end

    assign abort  = !gnt_cs;
    assign readdr = (gnt_addr != rom_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= G_NONE;
            rom_cs   <= 1'b0;
            rom_addr <= '0;
            scr_ok   <= 1'b0;
            chr_ok   <= 1'b0;
            obj_ok   <= 1'b0;
            req_data <= 32'd0;
        end else begin
            scr_ok <= 1'b0;
            chr_ok <= 1'b0;
            obj_ok <= 1'b0;
            case (state)
                IDLE: begin
                    if (winner != G_NONE) begin
                        grant    <= winner;
                        rom_addr <= win_addr;
                        rom_cs   <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE, WAIT: begin
                    // Abort beats re-address, and re-address discards a coincident rom_ok.
                    if (abort) begin
                        rom_cs <= 1'b0;
                        grant  <= G_NONE;
                        state  <= IDLE;
                    end else if (readdr) begin
                        rom_addr <= gnt_addr;
                        state    <= ISSUE;
                    end else if (state == WAIT && rom_ok) begin
                        req_data <= rom_data;
                        rom_cs   <= 1'b0;
                        scr_ok   <= (grant == G_SCR);
                        chr_ok   <= (grant == G_CHR);
                        obj_ok   <= (grant == G_OBJ);
                        state    <= DONE;
                    end else if (state == ISSUE) begin
                        state <= WAIT;
                    end
                end
                DONE: begin
                    grant <= G_NONE;
                    state <= IDLE;
                end
                default: begin
                    grant  <= G_NONE;
                    rom_cs <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= 4'd0;
        end else if (state == IDLE && winner == G_OBJ) begin
            starve_cnt <= 4'd0;
        end else if (obj_cs && grant != G_OBJ && starve_cnt < STARVE_MAX) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_jtkunio_rom_arb.sv
// Directed bench for jtkunio_rom_arb: arbitration order, latency, re-address, starvation, abort and reset.
module tb_jtkunio_rom_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        scr_cs, chr_cs, obj_cs;
    logic [17:0] scr_addr, chr_addr, obj_addr;
    logic        scr_ok, chr_ok, obj_ok;
    logic [31:0] req_data;
    logic        rom_cs;
    logic [17:0] rom_addr;
    logic [31:0] rom_data;
    logic        rom_ok;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    int seq[16];
    int n_seq;
    int overlaps;
    int scr_off;
    int exp5[10] = '{1, 2, 1, 2, 3, 1, 2, 1, 2, 3};

    always #5 clk = ~clk;

    function automatic logic [31:0] data_of(input logic [17:0] a);
        return {a, 14'h1ABC};
    endfunction

    // Downstream ROM model: data is a fixed function of the presented address.
    assign rom_data = data_of(rom_addr);

    jtkunio_rom_arb #(.AW(18), .STARVE(15)) dut (
        .clk      (clk),
        .rst      (rst),
        .scr_cs   (scr_cs),
        .scr_addr (scr_addr),
        .scr_ok   (scr_ok),
        .chr_cs   (chr_cs),
        .chr_addr (chr_addr),
        .chr_ok   (chr_ok),
        .obj_cs   (obj_cs),
        .obj_addr (obj_addr),
        .obj_ok   (obj_ok),
        .req_data (req_data),
        .rom_cs   (rom_cs),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .rom_ok   (rom_ok)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        scr_cs = 0; chr_cs = 0; obj_cs = 0;
        scr_addr = '0; chr_addr = '0; obj_addr = '0;
        rom_ok = 0;
        tick();
        tick();
        chk("rst_rom_cs",   32'(rom_cs), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_oks",      32'({scr_ok, chr_ok, obj_ok}), 32'd0);
        chk("rst_req_data", req_data, 32'd0);
        rst = 1'b0;
        tick();

        // 1: single scroll fetch, rom_ok delayed
        scr_addr = 18'h12345; scr_cs = 1;
        tick();
        chk("t1_issue_cs",   32'(rom_cs), 32'd1);
        chk("t1_issue_addr", 32'(rom_addr), 32'h12345);
        chk("t1_issue_ok",   32'(scr_ok), 32'd0);
        tick(); tick(); tick();
        chk("t1_wait_cs", 32'(rom_cs), 32'd1);
        chk("t1_wait_ok", 32'(scr_ok), 32'd0);
        rom_ok = 1;
        tick();
        chk("t1_done_ok",   32'(scr_ok), 32'd1);
        chk("t1_done_data", req_data, data_of(18'h12345));
        chk("t1_done_cs",   32'(rom_cs), 32'd0);
        scr_cs = 0; rom_ok = 0;
        tick();
        chk("t1_ok_once",  32'(scr_ok), 32'd0);
        chk("t1_data_hold", req_data, data_of(18'h12345));
        tick();

        // 2: simultaneous requests, service order scr, chr, obj
        scr_addr = 18'h01000; chr_addr = 18'h02000; obj_addr = 18'h03000;
        scr_cs = 1; chr_cs = 1; obj_cs = 1; rom_ok = 1;
        n_seq = 0; overlaps = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if ($countones({scr_ok, chr_ok, obj_ok}) > 1) overlaps++;
            if (scr_ok && n_seq < 16) begin
                seq[n_seq] = 1; n_seq++;
                chk("t2_scr_data", req_data, data_of(18'h01000));
                scr_cs = 0;
            end
            if (chr_ok && n_seq < 16) begin
                seq[n_seq] = 2; n_seq++;
                chk("t2_chr_data", req_data, data_of(18'h02000));
                chr_cs = 0;
            end
            if (obj_ok && n_seq < 16) begin
                seq[n_seq] = 3; n_seq++;
                chk("t2_obj_data", req_data, data_of(18'h03000));
                obj_cs = 0;
            end
        end
        chk("t2_count",   32'(n_seq), 32'd3);
        chk("t2_first",   32'(seq[0]), 32'd1);
        chk("t2_second",  32'(seq[1]), 32'd2);
        chk("t2_third",   32'(seq[2]), 32'd3);
        chk("t2_overlap", 32'(overlaps), 32'd0);
        rom_ok = 0;
        tick();

        // 3: rom_ok stuck high, minimum latency of 3 cycles
        chr_addr = 18'h2ABCD; chr_cs = 1; rom_ok = 1;
        tick();
        chk("t3_issue_cs", 32'(rom_cs), 32'd1);
        chk("t3_issue_ok", 32'(chr_ok), 32'd0);
        tick();
        chk("t3_wait_ok", 32'(chr_ok), 32'd0);
        tick();
        chk("t3_done_ok",   32'(chr_ok), 32'd1);
        chk("t3_done_data", req_data, data_of(18'h2ABCD));
        chr_cs = 0; rom_ok = 0;
        tick();

        // 4: obj re-addresses in WAIT, coincident rom_ok is discarded
        obj_addr = 18'h00100; obj_cs = 1;
        tick();
        chk("t4_issue_addr", 32'(rom_addr), 32'h00100);
        tick();
        obj_addr = 18'h08100; rom_ok = 1;
        tick();
        chk("t4_readdr_addr", 32'(rom_addr), 32'h08100);
        chk("t4_readdr_cs",   32'(rom_cs), 32'd1);
        chk("t4_readdr_ok",   32'(obj_ok), 32'd0);
        tick();
        chk("t4_reissue_ok", 32'(obj_ok), 32'd0);
        tick();
        chk("t4_done_ok",   32'(obj_ok), 32'd1);
        chk("t4_done_data", req_data, data_of(18'h08100));
        obj_cs = 0; rom_ok = 0;
        tick();
        chk("t4_single_ok", 32'(obj_ok), 32'd0);

        // 5: obj starved behind scr/chr until the counter reaches 15
        rst = 1; tick(); rst = 0;
        scr_addr = 18'h11111; chr_addr = 18'h22222; obj_addr = 18'h33333;
        scr_cs = 1; chr_cs = 1; obj_cs = 1; rom_ok = 1;
        n_seq = 0; scr_off = 0;
        for (int i = 0; i < 42; i++) begin
            tick();
            if (scr_off > 0) begin
                scr_off--;
                if (scr_off == 0) scr_cs = 1;
            end
            if (scr_ok && n_seq < 16) begin
                seq[n_seq] = 1; n_seq++;
                scr_cs = 0; scr_off = 2;
            end
            if (chr_ok && n_seq < 16) begin
                seq[n_seq] = 2; n_seq++;
            end
            if (obj_ok && n_seq < 16) begin
                seq[n_seq] = 3; n_seq++;
            end
        end
        chk("t5_count", 32'(n_seq), 32'd10);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("t5_seq%0d", i), 32'(seq[i]), 32'(exp5[i]));
        end
        scr_cs = 0; chr_cs = 0; obj_cs = 0; rom_ok = 0;
        tick(); tick(); tick(); tick();

        // 6: chr aborts mid-WAIT, then reset hits mid-WAIT of a scr fetch
        chr_addr = 18'h04000; chr_cs = 1;
        tick(); tick();
        chr_cs = 0;
        tick();
        chk("t6_abort_cs", 32'(rom_cs), 32'd0);
        chk("t6_abort_ok", 32'(chr_ok), 32'd0);
        rom_ok = 1;
        tick(); tick();
        chk("t6_no_late_ok", 32'(chr_ok), 32'd0);
        rom_ok = 0;
        scr_addr = 18'h05000; scr_cs = 1;
        tick(); tick();
        chk("t6_wait_cs", 32'(rom_cs), 32'd1);
        rst = 1;
        tick();
        chk("t6_rst_cs",   32'(rom_cs), 32'd0);
        chk("t6_rst_ok",   32'(scr_ok), 32'd0);
        chk("t6_rst_addr", 32'(rom_addr), 32'd0);
        rst = 0; scr_cs = 0; rom_ok = 1;
        tick(); tick(); tick();
        chk("t6_post_ok", 32'({scr_ok, chr_ok, obj_ok}), 32'd0);
        chk("t6_post_cs", 32'(rom_cs), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
